// File: rtl/pong_pkg.sv
// Shared types for the pong game-flow controller: state encoding, BCD score
// representation and the saturating BCD increment.
package pong_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_score_t;

    // Two-digit BCD increment; 99 holds rather than wrapping.
    function automatic bcd_score_t bcd_inc(input bcd_score_t s);
        bcd_score_t r;
        r = s;
        if (s.ones != 4'd9) begin
            r.ones = s.ones + 4'd1;
        end else if (s.tens != 4'd9) begin
            r.ones = '0;
            r.tens = s.tens + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register with synchronous clear and saturating increment.
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones
);

    bcd_score_t score_q, score_d;

    // Next score: clear wins over increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        score_d = score_q;
        if (clear) begin
            score_d = '0;
        end else if (inc) begin
            score_d = bcd_inc(score_q);
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is written with <= so every register samples pre-edge values regardless of block order.
        if (!reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign tens = score_q.tens;
    assign ones = score_q.ones;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller: frame-tick divider, start edge detect, IDLE/SERVE/
// PLAY/OVER sequencing, ball activation/re-serve and per-player BCD scores.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_BALLS     = 2,
    parameter int TICK_DIV_BITS = 21,
    parameter int SERVE_TICKS   = 50,
    parameter int WIN_SCORE     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pause,
    input  logic                 start,
    input  logic                 multi_ball,
    input  logic [NUM_BALLS-1:0] miss_left,
    input  logic [NUM_BALLS-1:0] miss_right,
    output logic                 frame_tick,
    output logic [NUM_BALLS-1:0] ball_active,
    output logic [NUM_BALLS-1:0] ball_serve,
    output logic [3:0]           score_left_tens,
    output logic [3:0]           score_left_ones,
    output logic [3:0]           score_right_tens,
    output logic [3:0]           score_right_ones,
    output logic [1:0]           game_state,
    output logic                 winner
);

    localparam bcd_score_t WIN_BCD = '{tens: bcd_t'(WIN_SCORE / 10), ones: bcd_t'(WIN_SCORE % 10)};
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);

    logic [TICK_DIV_BITS-1:0] div_q;
    logic                     start_q;
    logic                     start_edge;

    game_state_e              state_q, state_d;
    logic [7:0]               serve_cnt_q, serve_cnt_d;
    logic [NUM_BALLS-1:0]     active_q, active_d;
    logic [NUM_BALLS-1:0]     serve_q, serve_d;
    logic                     winner_q, winner_d;

    logic [NUM_BALLS-1:0]     launch_mask;
    logic [NUM_BALLS-1:0]     hit_mask;
    logic                     hit_found;
    logic                     hit_left;
    logic                     score_clear;
    logic                     inc_left;
    logic                     inc_right;
    logic                     scored_win;

    bcd_t                     left_tens, left_ones, right_tens, right_ones;
    bcd_score_t               next_left, next_right;

    // Frame divider (frozen by pause) and start history (always tracks).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (!pause) begin
                div_q <= div_q + TICK_DIV_BITS'(1);
            end
        end
    end

    assign frame_tick  = (&div_q) & ~pause;
    assign start_edge  = start & ~start_q & ~pause;
    assign launch_mask = multi_ball ? {NUM_BALLS{1'b1}} : NUM_BALLS'(1);
    assign next_left   = bcd_inc('{tens: left_tens, ones: left_ones});
    assign next_right  = bcd_inc('{tens: right_tens, ones: right_ones});

    // Game FSM next state, ball mask and score control.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        active_d    = active_q;
        serve_d     = '0;
        winner_d    = winner_q;
        score_clear = 1'b0;
        inc_left    = 1'b0;
        inc_right   = 1'b0;
        scored_win  = 1'b0;
        hit_found   = 1'b0;
        hit_left    = 1'b0;
        hit_mask    = '0;

        // Lowest-indexed active ball reporting a miss is the only one handled.
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!hit_found && active_q[i] && (miss_left[i] || miss_right[i])) begin
                hit_found   = 1'b1;
                hit_mask[i] = 1'b1;
                hit_left    = miss_left[i];
            end
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    score_clear = 1'b1;
                    winner_d    = 1'b0;
                    serve_cnt_d = SERVE_LOAD;
                    state_d     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    serve_cnt_d = serve_cnt_q - 8'd1;
                    if (serve_cnt_q == 8'd1) begin
                        state_d  = ST_PLAY;
                        active_d = launch_mask;
                        serve_d  = launch_mask;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick && hit_found) begin
                    active_d = active_q & ~hit_mask;
                    // miss_left means the ball got past the left paddle: right scores.
                    if (hit_left) begin
                        inc_right  = 1'b1;
                        scored_win = (next_right == WIN_BCD);
                    end else begin
                        inc_left   = 1'b1;
                        scored_win = (next_left == WIN_BCD);
                    end
                    if (scored_win) begin
                        state_d  = ST_OVER;
                        winner_d = ~hit_left;
                        active_d = '0;
                    end else if (active_d == '0) begin
                        serve_cnt_d = SERVE_LOAD;
                        state_d     = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Game FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            serve_cnt_q <= '0;
            active_q    <= '0;
            serve_q     <= '0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            active_q    <= active_d;
            serve_q     <= serve_d;
            winner_q    <= winner_d;
        end
    end

    bcd_score_counter u_score_left (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (inc_left),
        .tens  (left_tens),
        .ones  (left_ones)
    );

    bcd_score_counter u_score_right (
        .clk   (clk),
        .reset (reset),
        .clear (score_clear),
        .inc   (inc_right),
        .tens  (right_tens),
        .ones  (right_ones)
    );

    assign ball_active      = active_q;
    assign ball_serve       = serve_q;
    assign winner           = winner_q;
    assign game_state       = state_q;
    assign score_left_tens  = left_tens;
    assign score_left_ones  = left_ones;
    assign score_right_tens = right_tens;
    assign score_right_ones = right_ones;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a short divider and low win score.
module tb_pong_game_ctrl;

    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          pause;
    logic          start;
    logic          multi_ball;
    logic [NB-1:0] miss_left;
    logic [NB-1:0] miss_right;
    logic          frame_tick;
    logic [NB-1:0] ball_active;
    logic [NB-1:0] ball_serve;
    logic [3:0]    score_left_tens, score_left_ones;
    logic [3:0]    score_right_tens, score_right_ones;
    logic [1:0]    game_state;
    logic          winner;

    int n_vec  = 0;
    int n_miss = 0;

    pong_game_ctrl #(
        .NUM_BALLS     (NB),
        .TICK_DIV_BITS (4),
        .SERVE_TICKS   (3),
        .WIN_SCORE     (3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pause            (pause),
        .start            (start),
        .multi_ball       (multi_ball),
        .miss_left        (miss_left),
        .miss_right       (miss_right),
        .frame_tick       (frame_tick),
        .ball_active      (ball_active),
        .ball_serve       (ball_serve),
        .score_left_tens  (score_left_tens),
        .score_left_ones  (score_left_ones),
        .score_right_tens (score_right_tens),
        .score_right_ones (score_right_ones),
        .game_state       (game_state),
        .winner           (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Wait for the next frame_tick, then step one more cycle so its effect is visible.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 80);
        if (!frame_tick) check("tick_timeout", {31'd0, frame_tick}, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Three serve ticks, launching on the third.
    task automatic launch(input logic [NB-1:0] mask, input string tag);
        wait_tick();
        check({tag, "_serve1"}, game_state, 2'd1);
        wait_tick();
        check({tag, "_serve2"}, game_state, 2'd1);
        wait_tick();
        check({tag, "_play"}, game_state, 2'd2);
        check({tag, "_active"}, ball_active, mask);
        check({tag, "_serve_pulse"}, ball_serve, mask);
        @(negedge clk);
        check({tag, "_serve_clr"}, ball_serve, 2'b00);
    endtask

    initial begin
        int ticks;
        int n;
        reset      = 1'b0;
        pause      = 1'b0;
        start      = 1'b0;
        multi_ball = 1'b0;
        miss_left  = '0;
        miss_right = '0;

        // 1. Reset state and divider period.
        repeat (3) @(negedge clk);
        check("reset_outputs", {frame_tick, ball_active, ball_serve, score_left_tens, score_left_ones,
                                score_right_tens, score_right_ones, game_state, winner}, 24'd0);
        reset = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check($sformatf("tick_seq_%0d", i), {31'd0, frame_tick}, {31'd0, (i % 16) == 15});
        end
        check("idle_state", game_state, 2'd0);
        check("idle_scores", {score_left_tens, score_left_ones, score_right_tens, score_right_ones}, 16'h0000);

        // 2. Start with multi-ball: two balls launch on the third tick.
        multi_ball = 1'b1;
        pulse_start();
        check("start_to_serve", game_state, 2'd1);
        launch(2'b11, "mb");

        // 3. Two misses: ball 0 has both bits (left wins priority), then ball 1.
        miss_left  = 2'b11;
        miss_right = 2'b01;
        wait_tick();
        check("miss1_right", {score_right_tens, score_right_ones}, 8'h01);
        check("miss1_left", {score_left_tens, score_left_ones}, 8'h00);
        check("miss1_active", ball_active, 2'b10);
        check("miss1_state", game_state, 2'd2);
        wait_tick();
        check("miss2_right", {score_right_tens, score_right_ones}, 8'h02);
        check("miss2_active", ball_active, 2'b00);
        check("miss2_state", game_state, 2'd1);
        miss_left  = '0;
        miss_right = '0;
        multi_ball = 1'b0;

        // 5. Pause mid-serve freezes divider and serve counter.
        wait_tick();
        check("pre_pause_state", game_state, 2'd1);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        ticks = 0;
        repeat (50) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        check("pause_no_tick", ticks, 0);
        check("pause_state", game_state, 2'd1);
        pause = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 80);
        check("resume_latency", n, 10);
        @(negedge clk);
        check("resume_serve", game_state, 2'd1);
        wait_tick();
        check("single_play", game_state, 2'd2);
        check("single_active", ball_active, 2'b01);
        check("single_serve", ball_serve, 2'b01);

        // 4. Right reaches the win score; further misses are ignored; restart.
        miss_left = 2'b01;
        wait_tick();
        check("rwin_score", {score_right_tens, score_right_ones}, 8'h03);
        check("rwin_state", game_state, 2'd3);
        check("rwin_winner", winner, 1'b0);
        check("rwin_active", ball_active, 2'b00);
        wait_tick();
        check("over_hold_score", {score_right_tens, score_right_ones}, 8'h03);
        check("over_hold_state", game_state, 2'd3);
        miss_left = '0;
        pulse_start();
        check("restart_state", game_state, 2'd1);
        check("restart_scores", {score_left_tens, score_left_ones, score_right_tens, score_right_ones}, 16'h0000);
        check("restart_winner", winner, 1'b0);

        // Left player wins.
        multi_ball = 1'b1;
        launch(2'b11, "lw1");
        miss_right = 2'b11;
        wait_tick();
        check("lmiss1_left", {score_left_tens, score_left_ones}, 8'h01);
        check("lmiss1_active", ball_active, 2'b10);
        check("lmiss1_state", game_state, 2'd2);
        wait_tick();
        check("lmiss2_left", {score_left_tens, score_left_ones}, 8'h02);
        check("lmiss2_state", game_state, 2'd1);
        miss_right = '0;
        launch(2'b11, "lw2");
        miss_right = 2'b01;
        wait_tick();
        check("lwin_score", {score_left_tens, score_left_ones}, 8'h03);
        check("lwin_right", {score_right_tens, score_right_ones}, 8'h00);
        check("lwin_state", game_state, 2'd3);
        check("lwin_winner", winner, 1'b1);
        check("lwin_active", ball_active, 2'b00);
        miss_right = '0;

        // Start inside PLAY is ignored; then asynchronous reset mid-play.
        pulse_start();
        check("restart2_state", game_state, 2'd1);
        launch(2'b11, "rst");
        pulse_start();
        check("start_in_play", game_state, 2'd2);
        check("start_in_play_active", ball_active, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {frame_tick, ball_active, ball_serve, score_left_tens, score_left_ones,
                              score_right_tens, score_right_ones, game_state, winner}, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Parametrised game-flow controller for the pong design. It replaces the top level's free-running clock divider, hard-wired second-ball enable and loose score wiring with one block. The block generates the frame tick, sequences idle/serve/play/game-over, and tracks per-player BCD scores from per-ball miss events. It activates and re-serves up to NUM_BALLS balls. It sits between the ball/paddle instances and the VGA controller.

Parameters:
NUM_BALLS, 2, number of ball channels managed (1..8)
TICK_DIV_BITS, 21, frame_tick period = 2^TICK_DIV_BITS clk cycles
SERVE_TICKS, 50, frame ticks spent in SERVE before balls launch (1..255)
WIN_SCORE, 11, points that end the game (1..99)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
pause  in  1  freezes divider and FSM while high
start  in  1  start/restart request; synchronous to clk, debounced upstream
multi_ball  in  1  enables balls 1..NUM_BALLS-1 at serve
miss_left  in  NUM_BALLS  ball i has passed the left paddle (right player scores); level, held until ball_serve[i]
miss_right  in  NUM_BALLS  ball i has passed the right paddle (left player scores); level, held until ball_serve[i]
frame_tick  out  1  one-cycle game-update strobe
ball_active  out  NUM_BALLS  ball i is in play
ball_serve  out  NUM_BALLS  one-cycle pulse: recentre ball i
score_left_tens, score_left_ones, score_right_tens, score_right_ones  out  4 each  BCD scores
game_state  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
winner  out  1  valid in OVER: 1 = left, 0 = right

Behaviour:
- Reset (reset low, async): state IDLE; divider, serve counter and start_q are 0; all outputs 0.
- Divider: TICK_DIV_BITS-bit counter increments each cycle unless pause. frame_tick is high for exactly one cycle when the counter equals all-ones and pause is low. With no pause, the first tick falls 2^TICK_DIV_BITS cycles after reset release.
- start_edge = start & ~start_q. start_q updates every cycle, including during pause. start_edge is ignored while pause is high.
- IDLE: on start_edge, clear both scores, load serve counter with SERVE_TICKS, go to SERVE.
- SERVE: on each frame_tick, decrement the serve counter. On the frame_tick that finds the counter at 1:
  - go to PLAY;
  - set ball_active[0]; also set ball_active[NUM_BALLS-1:1] if multi_ball;
  - pulse ball_serve on the same bits (registered, visible next cycle).
- PLAY: misses are evaluated only on frame_tick.
  - Only the lowest-indexed active ball with any miss bit is processed per tick. Other pending misses are processed on later ticks.
  - If both miss bits are set for the same ball, miss_left takes priority (right player scores).
  - Processed ball: ball_active[i] clears and the scorer's score increments, both on the cycle after the tick.
  - If the new score equals WIN_SCORE: go to OVER, set winner, clear all ball_active.
  - Else if no ball remains active: reload the serve counter, go to SERVE.
  - Otherwise stay in PLAY.
  - Miss bits of inactive balls are ignored.
- OVER: scores and winner are held. On start_edge, clear scores and winner, load the serve counter, go to SERVE.
- BCD increment: ones 9 -> 0 with tens+1. Tens saturates at 9 and ones at 9 (99 holds).
- Win compare: against WIN_SCORE split into constant tens/ones digits.
- pause: holds divider, FSM, counters and outputs. frame_tick stays 0. Resuming continues from the held divider value.
- start_edge in SERVE or PLAY has no effect.
- multi_ball is sampled only at the serve launch tick.

Decomposition:
- pong_pkg holds the game_state encoding (IDLE/SERVE/PLAY/OVER) and BCD digit width 4.
- One sub-module, bcd_score_counter: ports clk, reset, clear, inc; outputs tens, ones, with the saturation rule above. Instantiated twice.
- Divider, edge detect, FSM and ball mask live in pong_game_ctrl.

Test Plan:
All scenarios use TICK_DIV_BITS=4, SERVE_TICKS=3, WIN_SCORE=3, NUM_BALLS=2.
1. Release reset, idle 40 cycles -> frame_tick pulses at cycles 16 and 32, each one cycle; game_state=0; all scores 0.
2. start pulse, multi_ball=1 -> game_state=1; on the 3rd tick game_state=2, ball_active=2'b11, ball_serve=2'b11 for one cycle.
3. In PLAY, miss_left=2'b11 and miss_right[0]=1 held -> tick N: right ones=1, ball_active=2'b10; tick N+1: right ones=2, ball_active=0, game_state=1.
4. Right score reaches 3 -> game_state=3, winner=0, ball_active=0; further misses leave the score unchanged; start -> scores 0, game_state=1.
5. pause held 50 cycles mid-SERVE -> no frame_tick, divider and serve counter frozen; after release, the next tick arrives after the remaining divider count.
6. reset asserted mid-PLAY asynchronously (between clock edges) -> all outputs 0 before the next clk edge, game_state=0.
